// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, write-request struct and arbiter state for the regfile write arbiter
package regfile_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wr_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  function automatic logic [2**AW-1:0] onehot_wa(input logic [AW-1:0] wa);
    return {{(2**AW-1){1'b0}}, 1'b1} << wa;
  endfunction

endpackage

// File: rtl/regfile_wr_fifo.sv
// rtl/regfile_wr_fifo.sv - in-order aux write queue; exposes per-entry valid and address for hazard tracking
module regfile_wr_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  wr_req_t                 push_data_i,
  output wr_req_t                 head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [CW-1:0]           count_o,
  output logic [DEPTH-1:0]        valid_o,
  output logic [DEPTH-1:0][AW-1:0] entry_wa_o
);

  wr_req_t          mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset: every consumer qualifies it with valid_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_wa_o[i] = mem_q[i].wa;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the regfile write port between WB and queued aux results
// Optional REGFILE_WR_BYPASS_EN: aux writes skip the empty queue when the port is idle.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_wa,
  input  logic [DW-1:0]    wb_wd,
  input  logic             aux_valid,
  output logic             aux_ready,
  input  logic [AW-1:0]    aux_wa,
  input  logic [DW-1:0]    aux_wd,
  output logic             stall_wb,
  output logic             rf_we,
  output logic [AW-1:0]    rf_wa,
  output logic [DW-1:0]    rf_wd,
  output logic [2**AW-1:0] pending_mask,
  output logic [CW-1:0]    fifo_count,
  output logic             wb_waw_err
);

  arb_state_t       state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_wa_q, rf_wa_d;
  logic [DW-1:0]    rf_wd_q, rf_wd_d;
  logic             waw_q, waw_d;

  logic             wb_win, aux_fire, bypass, push, pop;
  logic [CW-1:0]    count_next;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic [DEPTH-1:0] fifo_valid;
  logic [DEPTH-1:0][AW-1:0] fifo_wa;
  wr_req_t          fifo_head;
  wr_req_t          aux_req;

  assign aux_req = '{wa: aux_wa, wd: aux_wd};

  regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (aux_req),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt),
    .valid_o     (fifo_valid),
    .entry_wa_o  (fifo_wa)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) pending_mask = pending_mask | onehot_wa(fifo_wa[i]);
    end
  end

  always_comb begin
    wb_win   = (state_q == NORMAL) && wb_we && (wb_wa != '0);
    aux_fire = aux_valid && !fifo_full;
    bypass   = 1'b0;
`ifdef REGFILE_WR_BYPASS_EN
    bypass   = fifo_empty && (state_q == NORMAL) && !wb_win && aux_fire && (aux_wa != '0);
`endif
    push       = aux_fire && (aux_wa != '0) && !bypass;
    pop        = !fifo_empty && ((state_q == FORCE) || !wb_win);
    count_next = fifo_cnt + CW'(push) - CW'(pop);

    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      NORMAL: begin
        starve_d = (fifo_empty || pop) ? '0 : starve_q + 1'b1;
        if (starve_d == SW'(STARVE_LIMIT)) state_d = FORCE;
      end
      FORCE: begin
        starve_d = '0;
        if (count_next == '0) state_d = NORMAL;
      end
      default: begin
        state_d  = NORMAL;
        starve_d = '0;
      end
    endcase

    rf_we_d = wb_win || pop || bypass;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (wb_win) begin
      rf_wa_d = wb_wa;
      rf_wd_d = wb_wd;
    end else if (pop) begin
      rf_wa_d = fifo_head.wa;
      rf_wd_d = fifo_head.wd;
    end else if (bypass) begin
      rf_wa_d = aux_wa;
      rf_wd_d = aux_wd;
    end

    waw_d = wb_win && pending_mask[wb_wa];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
      waw_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
      waw_q    <= waw_d;
    end
  end

  assign aux_ready  = !fifo_full;
  assign stall_wb   = (state_q == FORCE);
  assign rf_we      = rf_we_q;
  assign rf_wa      = rf_wa_q;
  assign rf_wd      = rf_wd_q;
  assign fifo_count = fifo_cnt;
  assign wb_waw_err = waw_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_wa;
  logic [31:0] aux_wd;
  logic        stall_wb;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        wb_waw_err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wb_we        (wb_we),
    .wb_wa        (wb_wa),
    .wb_wd        (wb_wd),
    .aux_valid    (aux_valid),
    .aux_ready    (aux_ready),
    .aux_wa       (aux_wa),
    .aux_wd       (aux_wd),
    .stall_wb     (stall_wb),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count),
    .wb_waw_err   (wb_waw_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    wb_we     = 1'b0;
    wb_wa     = '0;
    wb_wd     = '0;
    aux_valid = 1'b0;
    aux_wa    = '0;
    aux_wd    = '0;
    repeat (2) tick();
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_wa", 64'(rf_wa), 64'd0);
    chk("rst_stall", 64'(stall_wb), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_ready", 64'(aux_ready), 64'd1);
    reset_n = 1'b1;
    tick();

    // aux alone: r3 <- A5A5
    aux_valid = 1'b1; aux_wa = 5'd3; aux_wd = 32'hA5A5;
    chk("solo_ready", 64'(aux_ready), 64'd1);
    tick();
    aux_valid = 1'b0;
`ifdef REGFILE_WR_BYPASS_EN
    chk("solo_byp_we", 64'(rf_we), 64'd1);
    chk("solo_byp_wa", 64'(rf_wa), 64'd3);
    chk("solo_byp_wd", 64'(rf_wd), 64'hA5A5);
    chk("solo_byp_cnt", 64'(fifo_count), 64'd0);
    tick();
    chk("solo_byp_idle", 64'(rf_we), 64'd0);
`else
    chk("solo_q_we", 64'(rf_we), 64'd0);
    chk("solo_q_cnt", 64'(fifo_count), 64'd1);
    chk("solo_q_mask", 64'(pending_mask), 64'h8);
    tick();
    chk("solo_we", 64'(rf_we), 64'd1);
    chk("solo_wa", 64'(rf_wa), 64'd3);
    chk("solo_wd", 64'(rf_wd), 64'hA5A5);
    chk("solo_cnt", 64'(fifo_count), 64'd0);
    chk("solo_mask", 64'(pending_mask), 64'd0);
    tick();
    chk("solo_idle", 64'(rf_we), 64'd0);
`endif

    // contention: WB r5 every cycle, aux r7 starves then is forced out
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h55;
    aux_valid = 1'b1; aux_wa = 5'd7; aux_wd = 32'h77;
    tick();
    aux_valid = 1'b0;
    chk("cont_wa0", 64'(rf_wa), 64'd5);
    chk("cont_cnt0", 64'(fifo_count), 64'd1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("cont_stall%0d", i), 64'(stall_wb), 64'd0);
    end
    tick();
    chk("cont_stall8", 64'(stall_wb), 64'd1);
    chk("cont_wa8", 64'(rf_wa), 64'd5);
    tick();
    chk("cont_force_we", 64'(rf_we), 64'd1);
    chk("cont_force_wa", 64'(rf_wa), 64'd7);
    chk("cont_force_wd", 64'(rf_wd), 64'h77);
    chk("cont_release", 64'(stall_wb), 64'd0);
    chk("cont_cnt", 64'(fifo_count), 64'd0);
    wb_we = 1'b0;
    tick();

    // full: four pushes r10..r13 behind busy WB, fifth refused, then in-order drain
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h55;
    for (int i = 0; i < 4; i++) begin
      aux_valid = 1'b1; aux_wa = 5'(10 + i); aux_wd = 32'(256 + i);
      chk($sformatf("full_ready%0d", i), 64'(aux_ready), 64'd1);
      tick();
    end
    aux_wa = 5'd14; aux_wd = 32'hEE;
    chk("full_cnt", 64'(fifo_count), 64'd4);
    chk("full_ready", 64'(aux_ready), 64'd0);
    chk("full_mask", 64'(pending_mask), 64'h3C00);
    tick();
    chk("full_reject_cnt", 64'(fifo_count), 64'd4);
    aux_valid = 1'b0; wb_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain_we%0d", i), 64'(rf_we), 64'd1);
      chk($sformatf("drain_wa%0d", i), 64'(rf_wa), 64'(10 + i));
      chk($sformatf("drain_wd%0d", i), 64'(rf_wd), 64'(256 + i));
      chk($sformatf("drain_cnt%0d", i), 64'(fifo_count), 64'(3 - i));
    end
    tick();

    // r0: WB to r0 is an idle slot; aux to r0 is dropped
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h55;
    aux_valid = 1'b1; aux_wa = 5'd20; aux_wd = 32'h2020;
    tick();
    aux_valid = 1'b0; wb_wa = 5'd0;
    tick();
    chk("r0_wb_we", 64'(rf_we), 64'd1);
    chk("r0_wb_wa", 64'(rf_wa), 64'd20);
    chk("r0_wb_cnt", 64'(fifo_count), 64'd0);
    wb_we = 1'b0;
    aux_valid = 1'b1; aux_wa = 5'd0; aux_wd = 32'hDEAD;
    chk("r0_aux_ready", 64'(aux_ready), 64'd1);
    tick();
    aux_valid = 1'b0;
    chk("r0_aux_we", 64'(rf_we), 64'd0);
    chk("r0_aux_cnt", 64'(fifo_count), 64'd0);
    tick();
    chk("r0_aux_we2", 64'(rf_we), 64'd0);

    // WAW: r9 queued, WB writes r9
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h55;
    aux_valid = 1'b1; aux_wa = 5'd9; aux_wd = 32'h99;
    tick();
    aux_valid = 1'b0;
    chk("waw_mask", 64'(pending_mask), 64'h200);
    chk("waw_quiet", 64'(wb_waw_err), 64'd0);
    wb_wa = 5'd9; wb_wd = 32'h900;
    tick();
    chk("waw_pulse", 64'(wb_waw_err), 64'd1);
    chk("waw_wb_wa", 64'(rf_wa), 64'd9);
    chk("waw_wb_wd", 64'(rf_wd), 64'h900);
    wb_wa = 5'd5;
    tick();
    chk("waw_one_cycle", 64'(wb_waw_err), 64'd0);
    wb_we = 1'b0;
    tick();
    chk("waw_drain_wa", 64'(rf_wa), 64'd9);
    chk("waw_drain_wd", 64'(rf_wd), 64'h99);
    chk("waw_drain_cnt", 64'(fifo_count), 64'd0);

    // async reset mid-traffic discards queued writes
    wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h55;
    for (int i = 1; i <= 3; i++) begin
      aux_valid = 1'b1; aux_wa = 5'(i); aux_wd = 32'(i);
      tick();
    end
    aux_valid = 1'b0;
    chk("mid_cnt", 64'(fifo_count), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_wa", 64'(rf_wa), 64'd0);
    chk("mid_rst_wd", 64'(rf_wd), 64'd0);
    chk("mid_rst_cnt", 64'(fifo_count), 64'd0);
    chk("mid_rst_mask", 64'(pending_mask), 64'd0);
    chk("mid_rst_stall", 64'(stall_wb), 64'd0);
    chk("mid_rst_waw", 64'(wb_waw_err), 64'd0);
    wb_we = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_we%0d", i), 64'(rf_we), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
